typing_session_ctrl: RTL

// - Sequences a typing session: owns the cursor (col,row), per-character status RAM and score counters.
// - Arbitrates the single-port status RAM between the pixel pipeline's read requests and keystroke write-backs.
// - Sits between correct_counter-style keystroke pulses and the ascii_gen renderer in the VGA top level.

---
 rtl/typing_session_ctrl_pkg.sv | 23 ++
 rtl/typing_session_ctrl_status_ram.sv | 30 +++
 rtl/typing_session_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/typing_session_ctrl_pkg.sv
// Shared types for the typing session controller: status codes, FSM states, counter width.
package typing_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_UNTYPED = 2'b00,
    ST_CORRECT = 2'b01,
    ST_WRONG   = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/typing_session_ctrl_status_ram.sv
// Single-port per-character status RAM, 2 bits per cell, registered read that holds between reads.
module status_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [1:0]    wdata,
  output logic [1:0]    rdata
);

  logic [1:0] mem [DEPTH];
  logic [1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read register only updates on a read so the renderer sees a stable value otherwise.
  always_ff @(posedge clk) begin
    if (reset)   rdata_q <= 2'b00;
    else if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/typing_session_ctrl.sv
// Typing session sequencer: cursor, score counters, status RAM sweep and read/write arbitration.
// Optional backspace key input is enabled with `define TYPING_BACKSPACE_EN.
module typing_session_ctrl
  import typing_pkg::*;
#(
  parameter int COLS  = 64,
  parameter int ROWS  = 8,
  parameter int COL_W = 6,
  parameter int ROW_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             key_valid,
  input  logic             key_correct,
`ifdef TYPING_BACKSPACE_EN
  input  logic             key_back,
`endif
  output logic             key_ready,
  input  logic             disp_req,
  input  logic [COL_W-1:0] disp_col,
  input  logic [ROW_W-1:0] disp_row,
  output logic [1:0]       disp_status,
  output logic             disp_status_valid,
  output logic [COL_W-1:0] cursor_col,
  output logic [ROW_W-1:0] cursor_row,
  output logic [CNT_W-1:0] correct_cnt,
  output logic [CNT_W-1:0] error_cnt,
  output logic             busy,
  output logic             done
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);

  state_e           state_q, state_d;
  logic [AW-1:0]    clr_q, clr_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] cor_q, cor_d, err_q, err_d;
  logic             pend_q, pend_d;
  logic [AW-1:0]    paddr_q, paddr_d;
  logic [1:0]       pdata_q, pdata_d;
  logic             last_q, last_d;
  logic             dvld_q;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [1:0]    ram_wdata;
  logic [AW-1:0] disp_addr, cur_addr;
  logic          at_last, col_end;

  assign disp_addr = AW'(disp_row) * AW'(COLS) + AW'(disp_col);
  assign cur_addr  = AW'(row_q) * AW'(COLS) + AW'(col_q);
  assign col_end   = (col_q == COL_W'(COLS - 1));
  assign at_last   = col_end && (row_q == ROW_W'(ROWS - 1));

`ifdef TYPING_BACKSPACE_EN
  logic [COL_W-1:0] bk_col;
  logic [ROW_W-1:0] bk_row;
  logic             at_home;
  assign at_home = (col_q == '0) && (row_q == '0);
  assign bk_col  = (col_q == '0) ? COL_W'(COLS - 1) : col_q - 1'b1;
  assign bk_row  = (col_q == '0) ? row_q - 1'b1 : row_q;
`endif

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    col_d     = col_q;
    row_d     = row_q;
    cor_d     = cor_q;
    err_d     = err_q;
    pend_d    = pend_q;
    paddr_d   = paddr_q;
    pdata_d   = pdata_q;
    last_d    = last_q;
    key_ready = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = disp_addr;
    ram_wdata = ST_UNTYPED;

    case (state_q)
      S_CLEAR: begin
        if (!disp_req) begin
          ram_we   = 1'b1;
          ram_addr = clr_q;
          if (clr_q == AW'(CELLS - 1)) begin
            state_d = S_IDLE;
            clr_d   = '0;
          end else begin
            clr_d = clr_q + 1'b1;
          end
        end
      end
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        key_ready = !pend_q;
        if (pend_q && !disp_req) begin
          ram_we    = 1'b1;
          ram_addr  = paddr_q;
          ram_wdata = pdata_q;
          pend_d    = 1'b0;
          if (last_q) begin
            state_d = S_DONE;
            last_d  = 1'b0;
          end
        end
        if (key_ready && key_valid) begin
          pend_d  = 1'b1;
          paddr_d = cur_addr;
          pdata_d = key_correct ? ST_CORRECT : ST_WRONG;
          if (key_correct) cor_d = sat_inc(cor_q);
          else             err_d = sat_inc(err_q);
          // The final cell keeps the cursor in place; DONE waits for its write to land.
          if (at_last) begin
            last_d = 1'b1;
          end else if (col_end) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
`ifdef TYPING_BACKSPACE_EN
        else if (key_ready && key_back && !at_home) begin
          col_d   = bk_col;
          row_d   = bk_row;
          pend_d  = 1'b1;
          paddr_d = AW'(bk_row) * AW'(COLS) + AW'(bk_col);
          pdata_d = ST_UNTYPED;
        end
`endif
      end
      default: ;
    endcase

    // Restart from RUN/DONE: the sweep rewrites every cell, so a pending write is simply dropped.
    if (start && (state_q == S_RUN || state_q == S_DONE)) begin
      state_d = S_CLEAR;
      clr_d   = '0;
      col_d   = '0;
      row_d   = '0;
      cor_d   = '0;
      err_d   = '0;
      pend_d  = 1'b0;
      last_d  = 1'b0;
      ram_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CLEAR;
      clr_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      cor_q   <= '0;
      err_q   <= '0;
      pend_q  <= 1'b0;
      paddr_q <= '0;
      pdata_q <= ST_UNTYPED;
      last_q  <= 1'b0;
      dvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cor_q   <= cor_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      paddr_q <= paddr_d;
      pdata_q <= pdata_d;
      last_q  <= last_d;
      dvld_q  <= disp_req;
    end
  end

  status_ram #(.DEPTH(CELLS), .AW(AW)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .re    (disp_req),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (disp_status)
  );

  assign disp_status_valid = dvld_q;
  assign cursor_col        = col_q;
  assign cursor_row        = row_q;
  assign correct_cnt       = cor_q;
  assign error_cnt         = err_q;
  assign busy              = (state_q == S_CLEAR);
  assign done              = (state_q == S_DONE);

endmodule
